// File: rtl/mlp_pkg.sv
// Shared types and field layout for the MLP weight-load controller.
package mlp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_ERROR = 2'd3
  } wl_state_e;

  localparam int CFG_W        = 5;
  localparam int CFG_INFER_EN = 0;
  localparam int CFG_WR_EN    = 1;
  localparam int CFG_CLEAR    = 2;

  localparam int WT_ADDR_LSB = 16;
  localparam int WT_ADDR_W   = 7;
  localparam int WT_SEL_LSB  = 24;
  localparam int WT_SEL_W    = 8;

  localparam int SO_CFG_LSB    = 0;
  localparam int SO_ERR        = 5;
  localparam int SO_STATE_LSB  = 6;
  localparam int SO_LOADED_LSB = 8;

  function automatic logic [15:0] pack_status(input logic [7:0]       loaded,
                                              input wl_state_e        st,
                                              input logic             err,
                                              input logic [CFG_W-1:0] cfg);
    logic [15:0] s;
    s = '0;
    s[SO_CFG_LSB +: CFG_W]  = cfg;
    s[SO_ERR]               = err;
    s[SO_STATE_LSB +: 2]    = st;
    s[SO_LOADED_LSB +: 8]   = loaded;
    return s;
  endfunction

endpackage

// File: rtl/mlp_wl_counter.sv
// Per-lane accepted-word counter; saturates at EXP_WORDS and flags the lane loaded.
module mlp_wl_counter #(
  parameter int EXP_WORDS = 128
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clr,
  input  logic inc,
  input  logic restart,
  output logic loaded
);

  localparam int              CNT_W   = $clog2(EXP_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(EXP_WORDS);

  logic [CNT_W-1:0] count;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      if (restart)
        count <= CNT_W'(1);
      else if (count != CNT_MAX)
        count <= count + 1'b1;
    end
  end

  assign loaded = (count == CNT_MAX);

endmodule

// File: rtl/mlp_wload_ctrl.sv
// Weight-load controller: fans weight words out to per-lane buses, tracks load
// progress per lane, and gates the activation stream until all lanes are ready.
module mlp_wload_ctrl
  import mlp_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int DATA_W     = 16,
  parameter int EXP_WORDS  = 128
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         w_tvalid,
  input  logic [31:0]                  w_tdata,
  input  logic [15:0]                  set_in,
  input  logic                         set_en,
  output logic [15:0]                  set_out,
  output logic [NUM_LAYERS*8-1:0]      lw_tid,
  output logic [NUM_LAYERS*DATA_W-1:0] lw_tdata,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  input  logic [DATA_W-1:0]            s_tdata,
  input  logic                         s_tlast,
  output logic                         act_tvalid,
  input  logic                         act_tready,
  output logic [DATA_W-1:0]            act_tdata,
  output logic                         act_tlast
);

  localparam logic [7:0] LANE_MASK = 8'((1 << NUM_LAYERS) - 1);

  logic [CFG_W-1:0]      cfg_q;
  wl_state_e             state_q;
  logic                  err_q;
  logic                  in_pkt_q;
  logic                  gate_open_q;
  logic [NUM_LAYERS-1:0] loaded;
  logic [7:0]            loaded_ext;

  logic [WT_SEL_W-1:0]  w_sel;
  logic [WT_ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0]    w_data;
  logic                 clear_req, accept, bad_word, word_fwd, word_err;
  logic                 beat_acc;
  logic                 unused_w_bit;

  assign w_sel  = w_tdata[WT_SEL_LSB +: WT_SEL_W];
  assign w_addr = w_tdata[WT_ADDR_LSB +: WT_ADDR_W];
  assign w_data = w_tdata[DATA_W-1:0];
  assign unused_w_bit = w_tdata[23];

  assign clear_req = set_en & set_in[CFG_CLEAR];
  assign accept    = w_tvalid & cfg_q[CFG_WR_EN] & (w_sel != '0) & (state_q != ST_ERROR);
  assign bad_word  = ({1'b0, w_addr} >= 8'(EXP_WORDS)) | (|(w_sel & ~LANE_MASK));
  // A simultaneous clear suppresses the word entirely, including the error path.
  assign word_fwd  = accept & ~bad_word & ~clear_req;
  assign word_err  = accept &  bad_word & ~clear_req;

  for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_lane
    logic [7:0]        tid_q;
    logic [DATA_W-1:0] tdata_q;

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        tid_q   <= '0;
        tdata_q <= '0;
      end else if (word_fwd) begin
        tid_q   <= {w_sel[l], w_addr};
        tdata_q <= w_data;
      end else begin
        tid_q   <= '0;
      end
    end

    assign lw_tid[l*8 +: 8]             = tid_q;
    assign lw_tdata[l*DATA_W +: DATA_W] = tdata_q;

    mlp_wl_counter #(
      .EXP_WORDS(EXP_WORDS)
    ) u_cnt (
      .aclk    (aclk),
      .aresetn (aresetn),
      .clr     (clear_req),
      .inc     (word_fwd & w_sel[l]),
      .restart (state_q == ST_READY),
      .loaded  (loaded[l])
    );
  end

  assign beat_acc = s_tvalid & s_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cfg_q       <= '0;
      state_q     <= ST_IDLE;
      err_q       <= 1'b0;
      in_pkt_q    <= 1'b0;
      gate_open_q <= 1'b0;
    end else begin
      if (set_en) begin
        cfg_q            <= set_in[CFG_W-1:0];
        cfg_q[CFG_CLEAR] <= 1'b0;
      end

      if (clear_req) begin
        state_q <= ST_IDLE;
        err_q   <= 1'b0;
      end else if (word_err) begin
        state_q <= ST_ERROR;
        err_q   <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE:  if (word_fwd) state_q <= ST_LOAD;
          ST_LOAD:  if (&loaded)  state_q <= ST_READY;
          ST_READY: if (word_fwd) state_q <= ST_LOAD;
          default:  state_q <= ST_ERROR;
        endcase
      end

      if (beat_acc)
        in_pkt_q <= ~s_tlast;

      // Gate only moves between packets so a close never truncates one.
      if (!in_pkt_q)
        gate_open_q <= (state_q == ST_READY) & cfg_q[CFG_INFER_EN];
    end
  end

  assign loaded_ext = 8'(loaded);
  assign set_out    = pack_status(loaded_ext, state_q, err_q, cfg_q);

  assign act_tvalid = s_tvalid & gate_open_q;
  assign s_tready   = act_tready & gate_open_q;
  assign act_tdata  = s_tdata;
  assign act_tlast  = s_tlast;

endmodule

// File: tb/tb_mlp_wload_ctrl.sv
// Bench for mlp_wload_ctrl: directed scenarios plus randomized traffic against a lane-count model.
module tb_mlp_wload_ctrl;

  localparam int NL = 4;
  localparam int DW = 16;
  localparam int EW = 4;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              w_tvalid = 1'b0;
  logic [31:0]       w_tdata = '0;
  logic [15:0]       set_in = '0;
  logic              set_en = 1'b0;
  logic [15:0]       set_out;
  logic [NL*8-1:0]   lw_tid;
  logic [NL*DW-1:0]  lw_tdata;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic [DW-1:0]     s_tdata = '0;
  logic              s_tlast = 1'b0;
  logic              act_tvalid;
  logic              act_tready = 1'b0;
  logic [DW-1:0]     act_tdata;
  logic              act_tlast;

  always #5 aclk = ~aclk;

  mlp_wload_ctrl #(
    .NUM_LAYERS(NL),
    .DATA_W    (DW),
    .EXP_WORDS (EW)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .w_tvalid   (w_tvalid),
    .w_tdata    (w_tdata),
    .set_in     (set_in),
    .set_en     (set_en),
    .set_out    (set_out),
    .lw_tid     (lw_tid),
    .lw_tdata   (lw_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tdata    (s_tdata),
    .s_tlast    (s_tlast),
    .act_tvalid (act_tvalid),
    .act_tready (act_tready),
    .act_tdata  (act_tdata),
    .act_tlast  (act_tlast)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: integer word counts per lane, states 0..3 as in the register map.
  int          m_cfg, m_state, m_err, m_in_pkt, m_gate;
  int          m_cnt [NL];
  logic [7:0]  m_tid [NL];
  logic [15:0] m_tdata [NL];

  function automatic int m_loaded();
    int r = 0;
    for (int l = 0; l < NL; l++)
      if (m_cnt[l] == EW) r |= (1 << l);
    return r;
  endfunction

  function automatic logic [15:0] m_status();
    return 16'((m_loaded() << 8) | (m_state << 6) | (m_err << 5) | m_cfg);
  endfunction

  task automatic model_reset();
    m_cfg = 0; m_state = 0; m_err = 0; m_in_pkt = 0; m_gate = 0;
    for (int l = 0; l < NL; l++) begin
      m_cnt[l] = 0; m_tid[l] = '0; m_tdata[l] = '0;
    end
  endtask

  task automatic model_step();
    int sel, addr, n_state, n_err, n_cfg, n_in_pkt, n_gate;
    bit clr, acc, bad, fwd, er, all_ld, hs;
    sel    = int'(w_tdata[31:24]);
    addr   = int'(w_tdata[22:16]);
    clr    = set_en && set_in[2];
    all_ld = (m_loaded() == (1 << NL) - 1);
    acc    = w_tvalid && ((m_cfg >> 1) & 1) != 0 && sel != 0 && m_state != 3;
    bad    = (addr >= EW) || (sel >= (1 << NL));
    fwd    = acc && !bad && !clr;
    er     = acc && bad && !clr;

    n_state = m_state;
    if (clr)                        n_state = 0;
    else if (er)                    n_state = 3;
    else if (m_state == 0 && fwd)   n_state = 1;
    else if (m_state == 1 && all_ld) n_state = 2;
    else if (m_state == 2 && fwd)   n_state = 1;

    n_err = clr ? 0 : (er ? 1 : m_err);

    for (int l = 0; l < NL; l++) begin
      if (clr)
        m_cnt[l] = 0;
      else if (fwd && ((sel >> l) & 1) != 0)
        m_cnt[l] = (m_state == 2) ? 1 : ((m_cnt[l] < EW) ? m_cnt[l] + 1 : EW);
      if (fwd) begin
        m_tid[l]   = 8'((((sel >> l) & 1) << 7) | addr);
        m_tdata[l] = w_tdata[15:0];
      end else begin
        m_tid[l] = '0;
      end
    end

    n_cfg    = set_en ? (int'(set_in) & 'h1B) : m_cfg;
    hs       = s_tvalid && act_tready && (m_gate != 0);
    n_in_pkt = hs ? int'(!s_tlast) : m_in_pkt;
    n_gate   = (m_in_pkt != 0) ? m_gate : int'(m_state == 2 && (m_cfg & 1) != 0);

    m_state = n_state; m_err = n_err; m_cfg = n_cfg;
    m_in_pkt = n_in_pkt; m_gate = n_gate;
  endtask

  task automatic compare_all();
    logic [NL*8-1:0]  tid_exp;
    logic [NL*DW-1:0] td_exp;
    for (int l = 0; l < NL; l++) begin
      tid_exp[l*8 +: 8]   = m_tid[l];
      td_exp[l*DW +: DW]  = m_tdata[l];
    end
    check_eq("set_out",    set_out,    m_status());
    check_eq("lw_tid",     lw_tid,     tid_exp);
    check_eq("lw_tdata",   lw_tdata,   td_exp);
    check_eq("act_tvalid", act_tvalid, s_tvalid && m_gate != 0);
    check_eq("s_tready",   s_tready,   act_tready && m_gate != 0);
    check_eq("act_tdata",  act_tdata,  s_tdata);
    check_eq("act_tlast",  act_tlast,  s_tlast);
  endtask

  task automatic tick();
    @(posedge aclk);
    if (!aresetn) model_reset();
    else          model_step();
    #1 compare_all();
  endtask

  task automatic drive_word(input logic [7:0] sel, input logic [6:0] addr, input logic [15:0] data);
    w_tvalid = 1'b1;
    w_tdata  = {sel, 1'b0, addr, data};
    tick();
    w_tvalid = 1'b0;
  endtask

  task automatic write_cfg(input logic [15:0] v);
    set_en = 1'b1;
    set_in = v;
    tick();
    set_en = 1'b0;
  endtask

  task automatic load_all();
    for (int a = 0; a < EW; a++) drive_word(8'h0F, 7'(a), 16'($urandom));
    tick();
    tick();
  endtask

  logic [15:0] cfg_tbl [8] = '{16'h0003, 16'h0003, 16'h0004, 16'h0004,
                               16'h0003, 16'h0001, 16'h0002, 16'h0007};

  initial begin
    logic [31:0] tid_rep;
    model_reset();
    repeat (3) tick();
    check_eq("reset_status", set_out, 16'h0000);
    aresetn = 1'b1;
    tick();

    // Load all four lanes while the stream is held off
    write_cfg(16'h0003);
    s_tvalid = 1'b1; act_tready = 1'b1; s_tdata = 16'($urandom);
    for (int a = 0; a < EW; a++) begin
      drive_word(8'h0F, 7'(a), 16'($urandom));
      tid_rep = {4{8'h80 | 8'(a)}};
      check_eq("load_tid", lw_tid, tid_rep);
      check_eq("gated_tvalid", act_tvalid, 1'b0);
      check_eq("gated_tready", s_tready, 1'b0);
    end
    s_tvalid = 1'b0;
    tick();
    tick();
    check_eq("load_status", set_out, 16'h0F83);
    check_eq("gate_open", s_tready, 1'b1);

    // Three-beat packet through the open gate
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1; s_tdata = 16'($urandom); s_tlast = (i == 2);
      #1 check_eq("beat_pass", act_tvalid, 1'b1);
      tick();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    tick();

    // Close request after beat 2 of a 4-beat packet
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1; s_tdata = 16'($urandom); s_tlast = (i == 3);
      if (i == 2) begin set_en = 1'b1; set_in = 16'h0002; end
      #1 check_eq("midpkt_pass", act_tvalid, 1'b1);
      tick();
      set_en = 1'b0;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    tick();
    check_eq("gate_closed", s_tready, 1'b0);

    // Reload lane 1 from READY
    write_cfg(16'h0003);
    drive_word(8'h02, 7'd0, 16'($urandom));
    check_eq("reload_status", set_out, 16'h0D43);
    for (int a = 1; a < EW; a++) drive_word(8'h02, 7'(a), 16'($urandom));
    check_eq("reload_full", set_out[15:8], 8'h0F);
    tick();
    check_eq("reload_ready", set_out[7:6], 2'd2);

    // Out-of-range address
    drive_word(8'h0F, 7'd5, 16'($urandom));
    check_eq("err_no_fwd", lw_tid & 32'h80808080, 32'h0);
    check_eq("err_state", set_out[7:5], 3'b111);
    write_cfg(16'h0004);
    check_eq("clear_status", set_out, 16'h0000);

    // Asynchronous reset in the middle of an open-gate packet
    write_cfg(16'h0003);
    load_all();
    s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = 16'($urandom);
    tick();
    tick();
    #2 aresetn = 1'b0;
    #1 model_reset();
    check_eq("rst_tready", s_tready, 1'b0);
    check_eq("rst_tvalid", act_tvalid, 1'b0);
    check_eq("rst_status", set_out, 16'h0000);
    check_eq("rst_tid", lw_tid, 32'h0);
    check_eq("rst_tdata", lw_tdata, 64'h0);
    s_tvalid = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      int r;
      logic [7:0] sel;
      logic [6:0] addr;
      r    = int'($urandom_range(0, 9));
      sel  = (r == 0) ? 8'($urandom_range(0, 255)) : ((r == 1) ? 8'h00 : 8'($urandom_range(1, 15)));
      addr = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 3));
      w_tvalid   = ($urandom_range(0, 2) != 0);
      w_tdata    = {sel, 1'($urandom_range(0, 1)), addr, 16'($urandom)};
      set_en     = ($urandom_range(0, 11) == 0);
      set_in     = cfg_tbl[$urandom_range(0, 7)];
      s_tvalid   = 1'($urandom_range(0, 1));
      act_tready = ($urandom_range(0, 3) != 0);
      s_tlast    = ($urandom_range(0, 3) == 0);
      s_tdata    = 16'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        aresetn = 1'b0;
        #1 model_reset();
        compare_all();
        tick();
        aresetn = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
